noc_credit_rx_buffer: RTL and testbench

//  Receive end of the NoC credit-based link: the downstream partner of the sender-side credit counter.

---
 rtl/noc_pkg.sv | 15 +
 rtl/noc_rx_fifo.sv | 64 ++++++
 rtl/noc_credit_rx_buffer.sv | 80 ++++++++
 tb/tb_noc_credit_rx_buffer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC link types and defaults; the sender-side credit counter uses the same
// NOC_BUF_DEPTH as its initial credit count so credits always match receive storage.
package noc_pkg;

  localparam int NOC_FLIT_W    = 32;
  localparam int NOC_BUF_DEPTH = 4;

  typedef logic [NOC_FLIT_W-1:0] flit_t;

  // True when depth is a power of two, which lets pointers wrap by natural overflow.
  function automatic bit depth_is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/noc_rx_fifo.sv
// Receive flit storage: first-word fall-through FIFO, write visible one cycle after push.
// No internal backpressure; caller qualifies push, and pop on empty or push on full without pop is ignored.
module noc_rx_fifo
  import noc_pkg::*;
#(
  parameter int  FLIT_W    = NOC_FLIT_W,
  parameter int  BUF_DEPTH = NOC_BUF_DEPTH,
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1),
  localparam int PTR_W     = $clog2(BUF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] wdata,
  input  logic              pop,
  output logic [FLIT_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [FLIT_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(BUF_DEPTH));

  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head = mem[rd_ptr];

  // Storage is intentionally not reset; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_credit_rx_buffer.sv
// NoC credit-link receiver: buffers flits (1-cycle latency), returns one registered credit per dequeue.
// No upstream ready (credit-guaranteed); overflow writes are dropped, flagged only when NOC_RX_ERR_EN is defined.
module noc_credit_rx_buffer
  import noc_pkg::*;
#(
  parameter int  FLIT_W    = NOC_FLIT_W,
  parameter int  BUF_DEPTH = NOC_BUF_DEPTH,
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flit_valid_i,
  input  logic [FLIT_W-1:0] flit_data_i,
  output logic              flit_valid_o,
  output logic [FLIT_W-1:0] flit_data_o,
  input  logic              flit_ready_i,
  output logic              credit_o,
  output logic [CNT_W-1:0]  occupancy_o,
  output logic              overflow_err_o
);

  logic             pop;
  logic             push;
  logic             full;
  logic             empty;
  logic             credit_q;
  logic [CNT_W-1:0] count;

  assign flit_valid_o = ~empty;
  assign pop          = flit_valid_o & flit_ready_i;
  assign push         = flit_valid_i & (~full | pop);

  noc_rx_fifo #(
    .FLIT_W    (FLIT_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (flit_data_i),
    .pop   (pop),
    .head  (flit_data_o),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign occupancy_o = count;

  // Reset dominates, so flits discarded by reset never return credits.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= 1'b0;
    end else begin
      credit_q <= pop;
    end
  end

  assign credit_o = credit_q;

`ifdef NOC_RX_ERR_EN
  logic overflow;
  logic err_q;

  assign overflow = flit_valid_i & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (overflow) begin
      err_q <= 1'b1;
    end
  end

  assign overflow_err_o = err_q;
`else
  assign overflow_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_credit_rx_buffer.sv
// Directed bench for noc_credit_rx_buffer with default parameters (32-bit flits, depth 4).
module tb_noc_credit_rx_buffer;
  import noc_pkg::*;

  logic       clk;
  logic       rst;
  logic       flit_valid_i;
  flit_t      flit_data_i;
  logic       flit_valid_o;
  flit_t      flit_data_o;
  logic       flit_ready_i;
  logic       credit_o;
  logic [2:0] occupancy_o;
  logic       overflow_err_o;

  int checks   = 0;
  int failures = 0;
  int credits  = 0;
  logic exp_err;

  noc_credit_rx_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .flit_valid_i   (flit_valid_i),
    .flit_data_i    (flit_data_i),
    .flit_valid_o   (flit_valid_o),
    .flit_data_o    (flit_data_o),
    .flit_ready_i   (flit_ready_i),
    .credit_o       (credit_o),
    .occupancy_o    (occupancy_o),
    .overflow_err_o (overflow_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef NOC_RX_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b1; flit_valid_i = 1'b0; flit_data_i = '0; flit_ready_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", flit_valid_o, 0);
    chk("rst_occ", occupancy_o, 0);
    chk("rst_credit", credit_o, 0);
    chk("rst_err", overflow_err_o, 0);

    // 1: single flit, one-cycle latency, credit one cycle after pop
    flit_valid_i = 1'b1; flit_data_i = 32'hA5; flit_ready_i = 1'b1;
    tick();
    flit_valid_i = 1'b0;
    chk("t1_valid", flit_valid_o, 1);
    chk("t1_data", flit_data_o, 32'hA5);
    chk("t1_occ", occupancy_o, 1);
    chk("t1_credit_early", credit_o, 0);
    tick();
    chk("t1_credit", credit_o, 1);
    chk("t1_occ0", occupancy_o, 0);
    chk("t1_valid0", flit_valid_o, 0);
    tick();
    chk("t1_credit_once", credit_o, 0);

    // 2: fill with ready low, then drain in order
    flit_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      flit_valid_i = 1'b1; flit_data_i = i;
      tick();
      chk("t2_fill_credit", credit_o, 0);
    end
    flit_valid_i = 1'b0;
    chk("t2_occ_full", occupancy_o, 4);
    flit_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_data", flit_data_o, i);
      chk("t2_valid", flit_valid_o, 1);
      tick();
      chk("t2_credit", credit_o, 1);
    end
    chk("t2_occ0", occupancy_o, 0);
    tick();
    chk("t2_ready_empty_credit", credit_o, 0);
    chk("t2_ready_empty_occ", occupancy_o, 0);

    // 3: write at full with simultaneous pop
    flit_ready_i = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      flit_valid_i = 1'b1; flit_data_i = i;
      tick();
    end
    chk("t3_occ_full", occupancy_o, 4);
    flit_valid_i = 1'b1; flit_data_i = 32'h9; flit_ready_i = 1'b1;
    tick();
    flit_valid_i = 1'b0;
    chk("t3_occ_same", occupancy_o, 4);
    chk("t3_no_err", overflow_err_o, 0);
    chk("t3_credit", credit_o, 1);
    chk("t3_head6", flit_data_o, 6);
    tick(); chk("t3_head7", flit_data_o, 7);
    tick(); chk("t3_head8", flit_data_o, 8);
    tick(); chk("t3_head9", flit_data_o, 9);
    tick();
    chk("t3_occ0", occupancy_o, 0);

    // 4: overflow write is dropped
    flit_ready_i = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      flit_valid_i = 1'b1; flit_data_i = i;
      tick();
    end
    flit_valid_i = 1'b1; flit_data_i = 32'hF;
    tick();
    flit_valid_i = 1'b0;
    chk("t4_occ", occupancy_o, 4);
    chk("t4_err", overflow_err_o, exp_err);
    flit_ready_i = 1'b1;
    for (int i = 10; i <= 13; i++) begin
      chk("t4_drain", flit_data_o, i);
      tick();
    end
    chk("t4_empty_valid", flit_valid_o, 0);
    chk("t4_empty_occ", occupancy_o, 0);
    chk("t4_err_sticky", overflow_err_o, exp_err);

    // 5: continuous streaming across pointer wrap
    tick();
    credits = 0;
    for (int i = 0; i < 10; i++) begin
      flit_valid_i = 1'b1; flit_data_i = 32'h20 + i;
      tick();
      chk("t5_data", flit_data_o, 32'h20 + i);
      chk("t5_occ", occupancy_o, 1);
      if (credit_o === 1'b1) credits++;
    end
    flit_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (credit_o === 1'b1) credits++;
    end
    chk("t5_credit_count", credits, 10);
    chk("t5_occ0", occupancy_o, 0);

    // 6: reset with stored flits
    flit_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flit_valid_i = 1'b1; flit_data_i = 32'h40 + i;
      tick();
    end
    flit_valid_i = 1'b0;
    chk("t6_occ3", occupancy_o, 3);
    rst = 1'b1; flit_ready_i = 1'b1;
    tick();
    chk("t6_valid", flit_valid_o, 0);
    chk("t6_occ", occupancy_o, 0);
    chk("t6_credit", credit_o, 0);
    chk("t6_err", overflow_err_o, 0);
    rst = 1'b0;
    credits = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (credit_o === 1'b1) credits++;
    end
    chk("t6_no_credits", credits, 0);
    chk("t6_still_empty", flit_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
